// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the conv_window_mac engine.
package conv_pkg;

  // Load-state machine: empty -> loading kernel -> filling window -> streaming results
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_KLOAD = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam int DEF_BIT_LEN = 8;
  localparam int DEF_M_LEN   = 3;

  // Result width that cannot overflow: full product width plus growth for K*K terms
  function automatic int conv_len(input int bit_len, input int m_len);
    return 2 * bit_len + $clog2(m_len * m_len);
  endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if: row input stream, result output stream and kernel-loaded flag.
// master = row source / result sink, slave = the convolution engine.
interface conv_window_mac_if
  import conv_pkg::*;
#(
  parameter int BIT_LEN  = DEF_BIT_LEN,
  parameter int M_LEN    = DEF_M_LEN,
  parameter int CONV_LEN = conv_len(BIT_LEN, M_LEN)
);
  logic                       i_valid;
  logic                       i_selecK_I;
  logic [BIT_LEN*M_LEN-1:0]   i_data;
  logic                       o_ready;
  logic                       o_valid;
  logic                       i_ready;
  logic [CONV_LEN-1:0]        o_data;
  logic                       o_kernel_loaded;

  modport master (
    output i_valid, i_selecK_I, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_kernel_loaded
  );

  modport slave (
    input  i_valid, i_selecK_I, i_data, i_ready,
    output o_ready, o_valid, o_data, o_kernel_loaded
  );
endinterface

// File: rtl/conv_mac_tree.sv
// conv_mac_tree: registered K*K signed products, then registered sign-extended sum.
// The whole pipeline freezes when en is low; flush kills in-flight valids.
// Optional build macro CONV_RELU_EN clamps the registered sum at zero.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int BIT_LEN  = DEF_BIT_LEN,
  parameter int M_LEN    = DEF_M_LEN,
  parameter int CONV_LEN = conv_len(BIT_LEN, M_LEN)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [M_LEN*M_LEN*BIT_LEN-1:0]    kern,
  input  logic [M_LEN*M_LEN*BIT_LEN-1:0]    win,
  output logic                              out_valid,
  output logic [CONV_LEN-1:0]               out_data
);
  localparam int N  = M_LEN * M_LEN;
  localparam int PW = 2 * BIT_LEN;

  logic signed [PW-1:0]       prod_d [N];
  logic signed [PW-1:0]       prod_q [N];
  logic                       v1_q;
  logic signed [CONV_LEN-1:0] sum_d;
  logic signed [CONV_LEN-1:0] res_d;

  // Element-wise signed products of kernel and window, operands sign-extended to full width
  always_comb begin
    for (int e = 0; e < N; e++) begin
      prod_d[e] = $signed({{BIT_LEN{kern[e*BIT_LEN+BIT_LEN-1]}}, kern[e*BIT_LEN +: BIT_LEN]})
                * $signed({{BIT_LEN{win[e*BIT_LEN+BIT_LEN-1]}}, win[e*BIT_LEN +: BIT_LEN]});
    end
  end

  // Adder tree over the registered products, optionally clamped at zero
  always_comb begin
    sum_d = '0;
    for (int e = 0; e < N; e++) begin
      sum_d = sum_d + {{(CONV_LEN-PW){prod_q[e][PW-1]}}, prod_q[e]};
    end
`ifdef CONV_RELU_EN
    res_d = sum_d[CONV_LEN-1] ? '0 : sum_d;
`else
    res_d = sum_d;
`endif
  end

  // Stage 1: capture products when a window position is launched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      for (int e = 0; e < N; e++) prod_q[e] <= '0;
    end else if (en) begin
      v1_q <= in_valid && !flush;
      if (in_valid) begin
        for (int e = 0; e < N; e++) prod_q[e] <= prod_d[e];
      end
    end
  end

  // Stage 2: capture the sum; data holds its last value when no new result arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= v1_q && !flush;
      if (v1_q) out_data <= res_d;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: K x K signed convolution engine with kernel store, vertical sliding
// window and load FSM; arithmetic lives in conv_mac_tree.
// Optional build macro CONV_RELU_EN (consumed by conv_mac_tree) clamps results at zero.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int BIT_LEN  = DEF_BIT_LEN,
  parameter int M_LEN    = DEF_M_LEN,
  parameter int CONV_LEN = conv_len(BIT_LEN, M_LEN)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  conv_window_mac_if.slave bus
);
  localparam int ROW_W = BIT_LEN * M_LEN;
  localparam int CNT_W = $clog2(M_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(M_LEN);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       krow_q, krow_d, irow_q, irow_d;
  logic                   launch_q, launch_d;
  logic                   shift_k, shift_w, flush;
  logic                   stall, accept, kern_acc, img_acc;
  logic [ROW_W-1:0]       kern_q [M_LEN];
  logic [ROW_W-1:0]       win_q  [M_LEN];
  logic [M_LEN*ROW_W-1:0] kern_flat, win_flat;
  logic                   mac_valid;
  logic [CONV_LEN-1:0]    mac_data;

  assign stall    = mac_valid && !bus.i_ready;
  assign accept   = bus.i_valid && !stall;
  assign kern_acc = accept && !bus.i_selecK_I;
  assign img_acc  = accept && bus.i_selecK_I;

  assign bus.o_ready         = !stall;
  assign bus.o_valid         = mac_valid;
  assign bus.o_data          = mac_data;
  assign bus.o_kernel_loaded = (state_q == S_FILL) || (state_q == S_RUN);

  // Next-state logic: kernel loading, window filling, result launch and kernel restart
  always_comb begin
    state_d  = state_q;
    krow_d   = krow_q;
    irow_d   = irow_q;
    launch_d = 1'b0;
    shift_k  = 1'b0;
    shift_w  = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (kern_acc) begin
          shift_k = 1'b1;
          krow_d  = CNT_ONE;
          state_d = S_KLOAD;
        end
      end
      S_KLOAD: begin
        if (kern_acc) begin
          shift_k = 1'b1;
          if (krow_q == CNT_LAST) begin
            krow_d  = CNT_FULL;
            irow_d  = '0;
            state_d = S_FILL;
          end else begin
            krow_d = krow_q + CNT_ONE;
          end
        end
      end
      S_FILL, S_RUN: begin
        if (kern_acc) begin
          shift_k = 1'b1;
          flush   = 1'b1;
          krow_d  = CNT_ONE;
          irow_d  = '0;
          state_d = S_KLOAD;
        end else if (img_acc) begin
          shift_w = 1'b1;
          if (irow_q != CNT_FULL) irow_d = irow_q + CNT_ONE;
          if ((state_q == S_RUN) || (irow_q == CNT_LAST)) begin
            launch_d = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Control registers; everything freezes while the output is stalled
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_EMPTY;
      krow_q   <= '0;
      irow_q   <= '0;
      launch_q <= 1'b0;
    end else if (!stall) begin
      state_q  <= state_d;
      krow_q   <= krow_d;
      irow_q   <= irow_d;
      launch_q <= launch_d;
    end
  end

  // Kernel and window row stores: new rows enter at the bottom, older rows move up
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < M_LEN; r++) begin
        kern_q[r] <= '0;
        win_q[r]  <= '0;
      end
    end else begin
      if (shift_k) begin
        for (int r = 0; r < M_LEN - 1; r++) kern_q[r] <= kern_q[r+1];
        kern_q[M_LEN-1] <= bus.i_data;
      end
      if (shift_w) begin
        for (int r = 0; r < M_LEN - 1; r++) win_q[r] <= win_q[r+1];
        win_q[M_LEN-1] <= bus.i_data;
      end
    end
  end

  // Flatten row stores so kernel element (r,c) lines up with window element (r,c)
  always_comb begin
    kern_flat = '0;
    win_flat  = '0;
    for (int r = 0; r < M_LEN; r++) begin
      kern_flat[r*ROW_W +: ROW_W] = kern_q[r];
      win_flat[r*ROW_W +: ROW_W]  = win_q[r];
    end
  end

  conv_mac_tree #(
    .BIT_LEN  (BIT_LEN),
    .M_LEN    (M_LEN),
    .CONV_LEN (CONV_LEN)
  ) u_mac (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .en        (!stall),
    .flush     (flush),
    .in_valid  (launch_q),
    .kern      (kern_flat),
    .win       (win_flat),
    .out_valid (mac_valid),
    .out_data  (mac_data)
  );

endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: scoreboard bench for conv_window_mac (3x3, 8-bit signed).
// Expected results come from a behavioural model updated on each accepted row.
module tb_conv_window_mac;
  import conv_pkg::*;

  localparam int BIT_LEN  = 8;
  localparam int M_LEN    = 3;
  localparam int CONV_LEN = conv_len(BIT_LEN, M_LEN);
  localparam int ROW_W    = BIT_LEN * M_LEN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  conv_window_mac_if #(.BIT_LEN(BIT_LEN), .M_LEN(M_LEN), .CONV_LEN(CONV_LEN)) bus();

  conv_window_mac #(.BIT_LEN(BIT_LEN), .M_LEN(M_LEN), .CONV_LEN(CONV_LEN)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int     total = 0;
  int     bad   = 0;
  int     n_out = 0;
  int     sb_q[$];
  int     mk[M_LEN][M_LEN];
  int     mw[M_LEN][M_LEN];
  int     m_krow, m_irow;
  state_t m_state;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] fill_row(input logic [BIT_LEN-1:0] v);
    return {M_LEN{v}};
  endfunction

  task automatic model_reset();
    m_state = S_EMPTY;
    m_krow  = 0;
    m_irow  = 0;
    for (int r = 0; r < M_LEN; r++)
      for (int c = 0; c < M_LEN; c++) begin
        mk[r][c] = 0;
        mw[r][c] = 0;
      end
    sb_q.delete();
  endtask

  function automatic int model_result();
    int s = 0;
    for (int r = 0; r < M_LEN; r++)
      for (int c = 0; c < M_LEN; c++) s += mk[r][c] * mw[r][c];
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Behavioural model of one accepted row
  task automatic model_accept(input logic sel, input logic [ROW_W-1:0] data);
    if (!sel) begin
      for (int r = 0; r < M_LEN - 1; r++)
        for (int c = 0; c < M_LEN; c++) mk[r][c] = mk[r+1][c];
      for (int c = 0; c < M_LEN; c++) mk[M_LEN-1][c] = int'($signed(data[c*BIT_LEN +: BIT_LEN]));
      if (m_state == S_FILL || m_state == S_RUN) begin
        m_state = S_KLOAD;
        m_krow  = 1;
        m_irow  = 0;
        sb_q.delete();
      end else begin
        m_krow++;
        if (m_krow == M_LEN) begin
          m_state = S_FILL;
          m_irow  = 0;
        end else begin
          m_state = S_KLOAD;
        end
      end
    end else if (m_state == S_FILL || m_state == S_RUN) begin
      for (int r = 0; r < M_LEN - 1; r++)
        for (int c = 0; c < M_LEN; c++) mw[r][c] = mw[r+1][c];
      for (int c = 0; c < M_LEN; c++) mw[M_LEN-1][c] = int'($signed(data[c*BIT_LEN +: BIT_LEN]));
      if (m_irow < M_LEN) m_irow++;
      if (m_irow == M_LEN) begin
        m_state = S_RUN;
        sb_q.push_back(model_result());
      end
    end
  endtask

  // Present one row and hold it until accepted; called and returns at posedge+1
  task automatic applyStimulus(input logic sel, input logic [ROW_W-1:0] data);
    bit   done = 0;
    logic rdy;
    bus.i_valid    = 1'b1;
    bus.i_selecK_I = sel;
    bus.i_data     = data;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = bus.o_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(sel, data);
        done = 1;
      end
    end
    #1;
    bus.i_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 30 && sb_q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain_left", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes at the next rising edge, so compare and pop here
  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) begin
      n_out++;
      if (sb_q.size() == 0) checkOutput("spurious_out", int'(bus.o_valid), 0);
      else checkOutput("result", $signed(bus.o_data), sb_q.pop_front());
    end
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequences; the scoreboard checks every produced result
  initial begin
    int n0;
    bus.i_valid    = 1'b0;
    bus.i_selecK_I = 1'b0;
    bus.i_data     = '0;
    bus.i_ready    = 1'b1;
    model_reset();
    #3;
    checkOutput("rst_o_valid", int'(bus.o_valid), 0);
    checkOutput("rst_o_data", int'(bus.o_data), 0);
    checkOutput("rst_kloaded", int'(bus.o_kernel_loaded), 0);
    checkOutput("rst_o_ready", int'(bus.o_ready), 1);
    do_reset();

    $display("[TB] all-ones kernel and image, latency");
    for (int k = 0; k < M_LEN; k++) begin
      applyStimulus(1'b0, fill_row(8'h01));
      checkOutput("kloaded_step", int'(bus.o_kernel_loaded), (k == M_LEN - 1) ? 1 : 0);
    end
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b1, fill_row(8'h01));
    @(negedge clk);
    @(negedge clk);
    checkOutput("lat_early", int'(bus.o_valid), 0);
    @(negedge clk);
    checkOutput("lat_valid", int'(bus.o_valid), 1);
    checkOutput("ones_value", $signed(bus.o_data), 9);
    @(negedge clk);
    checkOutput("single_pulse", int'(bus.o_valid), 0);
    wait_drain();

    $display("[TB] negative kernel");
    do_reset();
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b0, fill_row(8'hFF));
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b1, fill_row(8'h7F));
    wait_drain();

    $display("[TB] sliding window stream");
    do_reset();
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b0, fill_row(8'h01));
    n0 = n_out;
    for (int r = 1; r <= 5; r++) applyStimulus(1'b1, fill_row(8'(r)));
    wait_drain();
    checkOutput("stream_count", n_out - n0, 3);

    $display("[TB] backpressure");
    do_reset();
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b0, fill_row(8'h01));
    n0 = n_out;
    fork
      begin
        for (int r = 1; r <= 5; r++) applyStimulus(1'b1, fill_row(8'(r)));
      end
      begin
        for (int n = 0; n < 20 && !bus.o_valid; n++) @(negedge clk);
        @(posedge clk);
        #1 bus.i_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checkOutput("stall_ready", int'(bus.o_ready), 0);
          if (sb_q.size() == 0) checkOutput("stall_queue", sb_q.size(), 1);
          else checkOutput("stall_hold", $signed(bus.o_data), sb_q[0]);
        end
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
    join
    wait_drain();
    checkOutput("bp_count", n_out - n0, 3);

    $display("[TB] kernel restart");
    do_reset();
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b0, fill_row(8'h01));
    applyStimulus(1'b1, fill_row(8'h01));
    applyStimulus(1'b1, fill_row(8'h01));
    applyStimulus(1'b0, fill_row(8'h02));
    checkOutput("restart_kloaded", int'(bus.o_kernel_loaded), 0);
    applyStimulus(1'b0, fill_row(8'h02));
    checkOutput("restart_partial", int'(bus.o_kernel_loaded), 0);
    applyStimulus(1'b0, fill_row(8'h02));
    checkOutput("restart_loaded", int'(bus.o_kernel_loaded), 1);
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b1, fill_row(8'h01));
    wait_drain();

    $display("[TB] reset with a result pending");
    do_reset();
    bus.i_ready = 1'b0;
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b0, fill_row(8'h01));
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b1, fill_row(8'h01));
    for (int n = 0; n < 10 && !bus.o_valid; n++) @(negedge clk);
    checkOutput("pre_rst_valid", int'(bus.o_valid), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("async_o_valid", int'(bus.o_valid), 0);
    checkOutput("async_o_data", int'(bus.o_data), 0);
    checkOutput("async_kloaded", int'(bus.o_kernel_loaded), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.i_ready = 1'b1;
    n0 = n_out;
    for (int k = 0; k < M_LEN; k++) applyStimulus(1'b1, fill_row(8'h01));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("post_rst_silent", n_out - n0, 0);
    checkOutput("post_rst_kloaded", int'(bus.o_kernel_loaded), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
